// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key schedule for 128/192/256-bit keys, selected at run time.
// Produces one 32-bit schedule word per clock through a single SubWord path
// and presents all words on an MSB-first round-key bus once complete.

// AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup: entry n sits at bits [8n : 8n+7].
  always_comb begin
    out_byte = SBOX[{in_byte, 3'b000} +: 8];
  end
endmodule

module aes_key_schedule_seq #(
  parameter int KEY_BITS_MAX = 256
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic                                          start_i,
  input  logic [1:0]                                    key_len_i,
  input  logic [0:KEY_BITS_MAX-1]                       initial_key_i,
  output logic                                          busy_o,
  output logic                                          valid_o,
  output logic [3:0]                                    num_rounds_o,
  output logic [0:128*(6+KEY_BITS_MAX/32+1)-1]          round_keys_o
);
  localparam int NR_MAX = 6 + KEY_BITS_MAX / 32;
  localparam int NW     = 4 * (NR_MAX + 1);
  localparam int NK_MAX = KEY_BITS_MAX / 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r, state_nx;
  logic [31:0] w_r [0:NW-1];
  logic [5:0]  i_r;
  logic [2:0]  j_r;
  logic [3:0]  nk_r, nr_r;
  logic [7:0]  rcon_r;
  logic        busy_r, valid_r;

  logic [3:0]  nk_in_s, nr_in_s;
  logic        len_ok_s, accept_s, last_s;
  logic [31:0] t_prev_s, t_old_s, sub_in_s, sub_out_s, t_s, new_word_s;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Decode the requested key length and decide whether a start is accepted.
  always_comb begin
    nk_in_s  = 4'd4;
    nr_in_s  = 4'd10;
    len_ok_s = 1'b0;
    case (key_len_i)
      2'd0: begin
        nk_in_s  = 4'd4;
        nr_in_s  = 4'd10;
        len_ok_s = 1'b1;
      end
      2'd1: begin
        nk_in_s  = 4'd6;
        nr_in_s  = 4'd12;
        len_ok_s = (KEY_BITS_MAX >= 192);
      end
      2'd2: begin
        nk_in_s  = 4'd8;
        nr_in_s  = 4'd14;
        len_ok_s = (KEY_BITS_MAX >= 256);
      end
      default: begin
        nk_in_s  = 4'd4;
        nr_in_s  = 4'd10;
        len_ok_s = 1'b0;
      end
    endcase
    accept_s = start_i && len_ok_s && (state_r != EXPAND);
  end

  // One shared SubWord: four S-boxes fed by either RotWord(t) or t.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in_s[8*g +: 8]),
      .out_byte (sub_out_s[8*g +: 8])
    );
  end

  // Next schedule word: w[i] = w[i-Nk] ^ t, where t depends on the phase j.
  always_comb begin
    t_prev_s = w_r[i_r - 6'd1];
    t_old_s  = w_r[i_r - {2'b00, nk_r}];
    if (j_r == 3'd0) begin
      sub_in_s = rot_word(t_prev_s);
    end else begin
      sub_in_s = t_prev_s;
    end
    if (j_r == 3'd0) begin
      t_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((KEY_BITS_MAX > 192) && (nk_r == 4'd8) && (j_r == 3'd4)) begin
      t_s = sub_out_s;
    end else begin
      t_s = t_prev_s;
    end
    new_word_s = t_old_s ^ t_s;
    last_s     = (i_r == {nr_r, 2'b11});
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state: a start may be taken from IDLE or DONE, EXPAND runs to the last word.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx = EXPAND;
        else          state_nx = IDLE;
      end
      EXPAND: begin
        if (last_s) state_nx = DONE;
        else        state_nx = EXPAND;
      end
      DONE: begin
        if (accept_s) state_nx = EXPAND;
        else          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word counter, modulo-Nk phase counter, rcon and latched key geometry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      i_r     <= 6'd0;
      j_r     <= 3'd0;
      nk_r    <= 4'd0;
      nr_r    <= 4'd0;
      rcon_r  <= 8'h01;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      busy_r  <= (state_nx == EXPAND);
      valid_r <= (state_nx == DONE);
      if (accept_s) begin
        i_r    <= {2'b00, nk_in_s};
        j_r    <= 3'd0;
        nk_r   <= nk_in_s;
        nr_r   <= nr_in_s;
        rcon_r <= 8'h01;
      end else if (state_r == EXPAND) begin
        i_r <= i_r + 6'd1;
        if ({1'b0, j_r} == (nk_r - 4'd1)) j_r <= 3'd0;
        else                              j_r <= j_r + 3'd1;
        if (j_r == 3'd0) rcon_r <= xtime(rcon_r);
      end
    end
  end

  // Word storage: cleared and loaded with the key on start, one word per EXPAND cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NW; k++) w_r[k] <= 32'h00000000;
    end else if (accept_s) begin
      for (int k = 0; k < NW; k++) w_r[k] <= 32'h00000000;
      for (int k = 0; k < NK_MAX; k++) begin
        if (k < int'(nk_in_s)) w_r[k] <= initial_key_i[32*k +: 32];
      end
    end else if (state_r == EXPAND) begin
      w_r[i_r] <= new_word_s;
    end
  end

  assign busy_o       = busy_r;
  assign valid_o      = valid_r;
  assign num_rounds_o = nr_r;

  for (genvar g = 0; g < NW; g++) begin : g_bus
    assign round_keys_o[32*g +: 32] = w_r[g];
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq using the FIPS-197 key expansion vectors.
module tb_aes_key_schedule_seq;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] R12  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R14  = 128'hfe4890d1e6188d0b046df344706c631e;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    key_len;
  logic [0:255]  key_in;
  logic          busy, valid;
  logic [3:0]    nr;
  logic [0:1919] rk;

  typedef struct {
    int           nr;
    logic [127:0] r0;
    logic [127:0] rlast;
    int           exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic valid_q = 1'b0;

  aes_key_schedule_seq #(.KEY_BITS_MAX(256)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .key_len_i     (key_len),
    .initial_key_i (key_in),
    .busy_o        (busy),
    .valid_o       (valid),
    .num_rounds_o  (nr),
    .round_keys_o  (rk)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] rnd(input int r);
    return rk[128*r +: 128];
  endfunction

  // Monitor: on every rising valid, pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    logic upper;
    if (valid && !valid_q) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 128'(valid), 128'(1'b0));
      end else begin
        e = sb.pop_front();
        check("latency", 128'(cyc), 128'(e.exp_cyc));
        check("num_rounds", 128'(nr), 128'(e.nr));
        check("busy_at_valid", 128'(busy), 128'(1'b0));
        check("round0", rnd(0), e.r0);
        check("round_last", rnd(e.nr), e.rlast);
        upper = 1'b0;
        for (int r = e.nr + 1; r <= 14; r++) upper = upper | (|rnd(r));
        check("upper_rounds_zero", 128'(upper), 128'(1'b0));
      end
    end
    valid_q <= valid;
  end

  // Issue one start at a negedge; optionally push its expected result.
  task automatic issue(input logic [1:0] len, input logic [0:255] key, input int nrx,
                       input logic [127:0] rlast, input bit push);
    int nk;
    int n;
    exp_t e;
    nk = 4 + 2 * int'(len);
    n  = 4 * (nrx + 1) - nk;
    key_len = len;
    key_in  = key;
    start   = 1'b1;
    if (push) begin
      e.nr = nrx; e.r0 = key[0:127]; e.rlast = rlast; e.exp_cyc = cyc + 1 + n;
      sb.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    key_len = 2'd3;
    key_in  = {8{32'ha5a55a5a}};
    check("busy_after_start", 128'(busy), 128'(1'b1));
    check("valid_after_start", 128'(valid), 128'(1'b0));
  endtask

  task automatic wait_drain(input int maxc);
    int k;
    k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    reset_n = 1'b0;
    start   = 1'b0;
    key_len = 2'd0;
    key_in  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_valid", 128'(valid), 128'(1'b0));
    check("reset_nr", 128'(nr), 128'(4'd0));
    check("reset_keys", 128'(|rk), 128'(1'b0));
    reset_n = 1'b1;
    @(negedge clk);

    // Reserved key length from IDLE is ignored.
    key_len = 2'd3; key_in = K256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rej_busy", 128'(busy), 128'(1'b0));
    check("rej_valid", 128'(valid), 128'(1'b0));
    check("rej_nr", 128'(nr), 128'(4'd0));
    check("rej_keys", 128'(|rk), 128'(1'b0));

    // AES-128 with junk beyond the key length.
    issue(2'd0, {K128, 128'hdeadbeefcafef00d0123456789abcdef}, 10, R10, 1'b1);
    wait_drain(80);
    repeat (3) @(negedge clk);
    check("valid_held", 128'(valid), 128'(1'b1));
    check("round10_stable", rnd(10), R10);

    // AES-192 started from DONE.
    issue(2'd1, {K192, 64'hffffffffffffffff}, 12, R12, 1'b1);
    wait_drain(80);

    // AES-256 with a start pulse mid-expansion that must be ignored.
    issue(2'd2, K256, 14, R14, 1'b1);
    repeat (9) @(negedge clk);
    key_len = 2'd0; key_in = {K128, 128'h0}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(80);

    // Restart from DONE with the AES-128 key; old upper rounds clear at once.
    issue(2'd0, {K128, 128'h0}, 10, R10, 1'b1);
    check("restart_upper_zero", 128'(|rk[1408:1919]), 128'(1'b0));
    wait_drain(80);

    // AES-192 aborted by asynchronous reset, then AES-128.
    issue(2'd1, {K192, 64'h0}, 12, R12, 1'b0);
    repeat (19) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'(1'b0));
    check("abort_valid", 128'(valid), 128'(1'b0));
    check("abort_nr", 128'(nr), 128'(4'd0));
    check("abort_keys", 128'(|rk), 128'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(2'd0, {K128, 128'h0}, 10, R10, 1'b1);
    wait_drain(80);

    // Back-to-back: start held high restarts from DONE one cycle after valid.
    @(negedge clk);
    key_len = 2'd0; key_in = {K128, 128'h0}; start = 1'b1;
    c = cyc;
    sb.push_back('{10, K128, R10, c + 41});
    sb.push_back('{10, K128, R10, c + 82});
    repeat (42) @(negedge clk);
    start = 1'b0;
    wait_drain(120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Sequential, parametrised AES key schedule: the next generation of the combinational `key_expansion` block. It accepts a 128-, 192- or 256-bit cipher key, selected at run time, and generates one 32-bit schedule word per cycle with a single shared SubWord path. It stores all words and presents them on the same MSB-first round-key bus format the cipher core already consumes, with a start/valid handshake in place of combinational settling.

## Interface
- `KEY_BITS_MAX`, default 256. Largest supported key: 128, 192 or 256. Sets `NR_MAX = 6 + KEY_BITS_MAX/32` and the storage depth of `4*(NR_MAX+1)` words.
- `clk_i`  in  1  Clock. Single clock domain.
- `reset_n_i`  in  1  Asynchronous, active-low reset.
- `start_i`  in  1  Start request. Sampled only while `busy_o`=0.
- `key_len_i`  in  2  Key length: 0 = 128, 1 = 192, 2 = 256, 3 = reserved.
- `initial_key_i`  in  [0:KEY_BITS_MAX-1]  Cipher key, MSB-aligned at bit 0. For 128/192, bits beyond the key length are ignored.
- `busy_o`  out  1  Expansion in progress.
- `valid_o`  out  1  All words for the current key are stored. Held high until the next accepted start or reset.
- `num_rounds_o`  out  4  Nr latched at start: 10, 12 or 14.
- `round_keys_o`  out  [0:128*(NR_MAX+1)-1]  Round key r occupies bits [128r : 128r+127] (words w[4r..4r+3], w[4r] first). Rounds above Nr read zero.

## Operation
- States are IDLE, EXPAND and DONE. Reset enters IDLE.
- **Accepting a start.** In IDLE or DONE, `start_i`=1 with a legal length commits the following at the clock edge:
  - Clear all storage.
  - Write w[0..Nk-1] from the key, with Nk = 4, 6 or 8.
  - Latch Nk and Nr. Set i = Nk, rcon = 0x01, and j = 0, where j = i mod Nk is kept as a modulo counter with no divider.
  - Set `valid_o`=0 and `busy_o`=1, and enter EXPAND.
- **Rejected starts.**
  - `key_len_i`=3: start ignored, no state change.
  - Key length greater than `KEY_BITS_MAX`: start ignored, no state change.
  - `start_i` while in EXPAND: ignored.
- **EXPAND.** One word per cycle. Let t = w[i-1].
  - If j==0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), i.e. `(rcon<<1) ^ (rcon[7] ? 0x1B : 0)`.
  - Else if Nk==8 and j==4: t = SubWord(t).
  - Then w[i] = w[i-Nk] ^ t, written at the edge.
  - i increments and j wraps Nk-1 → 0.
- **Leaving EXPAND.** On the edge that writes the last word, w[4*Nr+3], enter DONE with `valid_o`=1 and `busy_o`=0.
- **S-box.** SubWord uses 4 instances of the existing `aes_sbox`, shared across every branch. There is exactly one SubWord per cycle.
- **Parameter variants.** With `KEY_BITS_MAX`=128, the j==4 branch and storage above 44 words are absent. `key_len_i` 1 and 2 are rejected.

## Timing
- **Reset values.**
  - `busy_o`=0, `valid_o`=0, `num_rounds_o`=0, `round_keys_o`=all zero.
  - rcon=0x01, state IDLE.
  - Reset is asynchronous and takes effect immediately, including mid-EXPAND. After reset a new start is required.
- **Start to valid.** With the start accepted at edge 0, `valid_o` rises after edge N, where N = 4(Nr+1) − Nk:
  - 128-bit: N = 40
  - 192-bit: N = 46
  - 256-bit: N = 52
- **Busy window.** `busy_o` is high from after edge 0 through edge N.
- **Output stability.** `round_keys_o` is registered.
  - Words appear as they are written.
  - Consumers must use the bus only while `valid_o`=1.
  - The bus is stable throughout DONE.
- **Restart from DONE.** `valid_o` falls after the accepting edge. Old words are zero from that edge onward.
- **Inputs.** `key_len_i` and `initial_key_i` are sampled only at the accepting edge. Later changes have no effect.
- **Back-to-back operation.** `start_i` held high continuously restarts at every DONE: one cycle of `valid_o` per key.

## Test plan
- **AES-128 (FIPS-197 A.1).** Key 2b7e151628aed2a6abf7158809cf4f3c, `key_len_i`=0.
  - `valid_o` rises after edge 40. `num_rounds_o`=10.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. Rounds 11–14 = 0.
- **AES-192 (A.2).** Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, `key_len_i`=1.
  - `valid_o` rises after edge 46. `num_rounds_o`=12.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
- **AES-256 (A.3).** Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, `key_len_i`=2.
  - `valid_o` rises after edge 52.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
  - Round 0 equals the key's first 128 bits.
- **Ignored starts.**
  - `start_i` pulsed at cycle 10 of an AES-256 run: no effect on timing or result.
  - `key_len_i`=3 with `start_i` from IDLE: `busy_o` stays 0 and outputs stay 0.
- **Reset mid-operation.** Deassert `reset_n_i` asynchronously at cycle 20 of an AES-192 run.
  - All outputs go to zero immediately.
  - A subsequent AES-128 start yields the A.1 result after edge 40.
- **Restart from DONE.** After the A.3 result, start with the A.1 key.
  - `valid_o` drops after the accepting edge.
  - Rounds 11–14 read zero.
  - Round 10 equals the A.1 value after edge 40.
